// File: rtl/ysyx_040729_ifu.sv
// Instruction fetch stage: owns the PC, handshakes with the I-cache port and
// buffers {pc, inst} pairs in a small FIFO feeding decode; redirects flush it.
module ysyx_040729_ifu #(
    parameter int              ADDR_WIDTH = 64,
    parameter int              INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 64'h8000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    input  logic                  if_ready,
    input  logic [INST_WIDTH-1:0] if_data_read,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0] pend_pc_reg, pend_pc_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [PTR_W-1:0]      head_reg, head_next;
    logic [PTR_W-1:0]      tail_reg, tail_next;

    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];

    logic                  fire;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redirect_target;

    // The request stays valid until it fires: RUN only leaves via fire or
    // redirect, and KILL keeps the same address until its response arrives.
    assign if_valid  = !reset && ((state_reg == S_RUN && count_reg < FULL) || state_reg == S_KILL);
    assign if_addr   = pc_reg;
    assign fire      = if_valid && if_ready;
    assign out_valid = !reset && (count_reg != '0);
    assign pop       = out_valid && out_ready;
    assign out_pc    = out_valid ? pc_mem[head_reg]   : '0;
    assign out_inst  = out_valid ? inst_mem[head_reg] : '0;
    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pend_pc_next = pend_pc_reg;
        count_next   = count_reg;
        head_next    = head_reg;
        tail_next    = tail_reg;
        push         = 1'b0;

        if (redirect_valid) begin
            // Flush wins over any same-cycle pop; an unfired request must
            // still complete, so its response is swallowed in KILL.
            count_next = '0;
            head_next  = '0;
            tail_next  = '0;
            if (if_valid && !fire) begin
                pend_pc_next = redirect_target;
                state_next   = S_KILL;
            end else begin
                pc_next    = redirect_target;
                state_next = S_RUN;
            end
        end else begin
            push = (state_reg == S_RUN) && fire;
            if (push) begin
                tail_next = tail_reg + PTR_W'(1);
                pc_next   = pc_reg + ADDR_WIDTH'(4);
            end
            if (pop) begin
                head_next = head_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

            case (state_reg)
                S_RUN:  if (count_next == FULL) state_next = S_HOLD;
                S_HOLD: if (pop) state_next = S_RUN;
                S_KILL: begin
                    if (fire) begin
                        pc_next    = pend_pc_reg;
                        state_next = S_RUN;
                    end
                end
                default: state_next = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= S_RUN;
            pc_reg      <= RESET_ADDR;
            pend_pc_reg <= RESET_ADDR;
            count_reg   <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pend_pc_reg <= pend_pc_next;
            count_reg   <= count_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
        end
    end

    // Payload storage needs no reset; out_pc/out_inst are masked while empty.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            pc_mem[tail_reg]   <= pc_reg;
            inst_mem[tail_reg] <= if_data_read;
        end
    end
endmodule

// File: tb/tb_ysyx_040729_ifu.sv
// Directed bench for the fetch stage; the I-cache returns addr[31:0] ^ 32'h13579BDF.
module tb_ysyx_040729_ifu;
    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] if_addr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_data_read;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    assign if_data_read = if_addr[31:0] ^ 32'h1357_9BDF;

    ysyx_040729_ifu dut (
        .clock          (clock),
        .reset          (reset),
        .if_addr        (if_addr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_data_read   (if_data_read),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    // Advance to the next cycle: inputs are changed just after the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic start(input logic ir, input logic ordy);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        if_ready = ir; out_ready = ordy;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        if_ready = 1'b1; out_ready = 1'b1;
        tick(); tick(); #1;
        tests++; if (if_valid !== 1'b0) begin failed++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_pc !== 64'h0 || out_inst !== 32'h0) begin failed++; $display("FAIL reset_out_data got %h/%h want 0/0", out_pc, out_inst); end
        $display("[TB] reset: if_valid=%b out_valid=%b", if_valid, out_valid);
    endtask

    task automatic test_stream();
        start(1'b1, 1'b1);
        tests++; if (if_valid !== 1'b1 || if_addr !== 64'h8000_0000 || out_valid !== 1'b0) begin failed++; $display("FAIL t1_c0 got v=%b a=%h ov=%b want 1/80000000/0", if_valid, if_addr, out_valid); end
        tick(); #1;
        tests++; if (if_addr !== 64'h8000_0004) begin failed++; $display("FAIL t1_c1_addr got %h want 80000004", if_addr); end
        tests++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || out_inst !== 32'h9357_9BDF) begin failed++; $display("FAIL t1_c1_out got %b/%h/%h want 1/80000000/93579bdf", out_valid, out_pc, out_inst); end
        tick(); #1;
        tests++; if (if_addr !== 64'h8000_0008 || out_pc !== 64'h8000_0004 || out_inst !== 32'h9357_9BDB) begin failed++; $display("FAIL t1_c2 got %h/%h/%h want 80000008/80000004/93579bdb", if_addr, out_pc, out_inst); end
        $display("[TB] stream: if_addr=%h out_pc=%h", if_addr, out_pc);
    endtask

    task automatic test_hold();
        start(1'b1, 1'b0);
        tick(); tick(); #1;
        tests++; if (if_valid !== 1'b0 || if_addr !== 64'h8000_0008) begin failed++; $display("FAIL t2_hold got v=%b a=%h want 0/80000008", if_valid, if_addr); end
        tests++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000) begin failed++; $display("FAIL t2_head got %b/%h want 1/80000000", out_valid, out_pc); end
        out_ready = 1'b1;
        tick(); out_ready = 1'b0; #1;
        tests++; if (if_valid !== 1'b1 || if_addr !== 64'h8000_0008 || out_pc !== 64'h8000_0004) begin failed++; $display("FAIL t2_resume got v=%b a=%h pc=%h want 1/80000008/80000004", if_valid, if_addr, out_pc); end
        $display("[TB] hold: if_valid=%b if_addr=%h", if_valid, if_addr);
    endtask

    task automatic test_kill();
        start(1'b1, 1'b1);
        tick();
        if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
        tick(); redirect_valid = 1'b0; #1;
        tests++; if (if_valid !== 1'b1 || if_addr !== 64'h8000_0004 || out_valid !== 1'b0) begin failed++; $display("FAIL t3_kill got v=%b a=%h ov=%b want 1/80000004/0", if_valid, if_addr, out_valid); end
        tick(); #1;
        tests++; if (if_addr !== 64'h8000_0004) begin failed++; $display("FAIL t3_held got %h want 80000004", if_addr); end
        if_ready = 1'b1;
        tick(); #1;
        tests++; if (if_addr !== 64'h8000_1000 || out_valid !== 1'b0) begin failed++; $display("FAIL t3_target got a=%h ov=%b want 80001000/0", if_addr, out_valid); end
        $display("[TB] kill: if_addr=%h out_valid=%b", if_addr, out_valid);
    endtask

    task automatic test_redirect_on_fire();
        start(1'b1, 1'b1);
        tick(); tick(); tick(); #1;
        tests++; if (if_addr !== 64'h8000_000C || out_valid !== 1'b1) begin failed++; $display("FAIL t4_pre got a=%h ov=%b want 8000000c/1", if_addr, out_valid); end
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        tick(); redirect_valid = 1'b0; #1;
        tests++; if (out_valid !== 1'b0 || if_valid !== 1'b1 || if_addr !== 64'h8000_2000) begin failed++; $display("FAIL t4_post got ov=%b v=%b a=%h want 0/1/80002000", out_valid, if_valid, if_addr); end
        $display("[TB] redirect_on_fire: if_addr=%h", if_addr);
    endtask

    task automatic test_double_redirect();
        start(1'b0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
        tick(); redirect_pc = 64'h8000_4000; #1;
        tests++; if (if_addr !== 64'h8000_0000 || if_valid !== 1'b1) begin failed++; $display("FAIL t5_kill got a=%h v=%b want 80000000/1", if_addr, if_valid); end
        tick(); redirect_valid = 1'b0; if_ready = 1'b1;
        tick(); #1;
        tests++; if (if_addr !== 64'h8000_4000 || out_valid !== 1'b0) begin failed++; $display("FAIL t5_target got a=%h ov=%b want 80004000/0", if_addr, out_valid); end
        tick(); #1;
        tests++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_4000 || out_inst !== 32'h9357_DBDF) begin failed++; $display("FAIL t5_out got %b/%h/%h want 1/80004000/9357dbdf", out_valid, out_pc, out_inst); end
        $display("[TB] double_redirect: out_pc=%h", out_pc);
    endtask

    task automatic test_reset_in_kill();
        start(1'b0, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_5000;
        tick(); redirect_valid = 1'b0; reset = 1'b1;
        tick(); #1;
        tests++; if (if_valid !== 1'b0 || out_valid !== 1'b0) begin failed++; $display("FAIL t6_reset got v=%b ov=%b want 0/0", if_valid, out_valid); end
        reset = 1'b0; if_ready = 1'b1; #1;
        tests++; if (if_valid !== 1'b1 || if_addr !== 64'h8000_0000) begin failed++; $display("FAIL t6_release got v=%b a=%h want 1/80000000", if_valid, if_addr); end
        tick(); #1;
        tests++; if (out_pc !== 64'h8000_0000 || if_addr !== 64'h8000_0004) begin failed++; $display("FAIL t6_run got pc=%h a=%h want 80000000/80000004", out_pc, if_addr); end
        $display("[TB] reset_in_kill: if_addr=%h", if_addr);
    endtask

    task automatic test_wrap();
        start(1'b1, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); redirect_valid = 1'b0; #1;
        tests++; if (if_addr !== 64'hFFFF_FFFF_FFFF_FFFC || out_valid !== 1'b0) begin failed++; $display("FAIL wrap_align got a=%h ov=%b want fffffffffffffffc/0", if_addr, out_valid); end
        tick(); #1;
        tests++; if (if_addr !== 64'h0 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_inst !== 32'hECA8_6423) begin failed++; $display("FAIL wrap_pc got a=%h pc=%h i=%h want 0/fffffffffffffffc/eca86423", if_addr, out_pc, out_inst); end
        $display("[TB] wrap: if_addr=%h out_pc=%h", if_addr, out_pc);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_kill();
        test_redirect_on_fire();
        test_double_redirect();
        test_reset_in_kill();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
